// File: rtl/ss_stack_pkg.sv
// Shared opcodes, control encodings, FSM states and per-opcode control decode
// for the stack sequencer.
package ss_stack_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_PUSH  = 3'd1;
   localparam logic [2:0] OP_POP   = 3'd2;
   localparam logic [2:0] OP_DUP   = 3'd3;
   localparam logic [2:0] OP_SWAP  = 3'd4;
   localparam logic [2:0] OP_OVER  = 3'd5;
   localparam logic [2:0] OP_BINOP = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   localparam logic [1:0] DP_HOLD = 2'b00;
   localparam logic [1:0] DP_INC  = 2'b01;
   localparam logic [1:0] DP_DEC  = 2'b10;

   localparam logic [2:0] TRS_A = 3'd0;
   localparam logic [2:0] TRS_B = 3'd1;
   localparam logic [2:0] TRS_C = 3'd2;
   localparam logic [2:0] TRS_D = 3'd3;
   localparam logic [2:0] TRS_E = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_REJ} state_t;

   typedef struct packed {
      logic [1:0] dp_inc;
      logic       reg_write;
      logic       tr_write;
      logic [2:0] tr_src;
   } ctl_t;

   function automatic logic two_cycle(input logic [2:0] op);
      return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
   endfunction

   function automatic logic is_grow(input logic [2:0] op);
      return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
   endfunction

   function automatic logic is_shrink(input logic [2:0] op);
      return (op == OP_POP) || (op == OP_BINOP);
   endfunction

   // Controls driven in the first execute cycle
   function automatic ctl_t ex1_ctl(input logic [2:0] op);
      ctl_t c;
      c = '0;
      case (op)
         OP_PUSH, OP_DUP, OP_OVER: c.dp_inc = DP_INC;
         OP_POP:   begin c.tr_write = 1'b1; c.tr_src = TRS_E; c.dp_inc = DP_DEC; end
         OP_SWAP:  begin c.reg_write = 1'b1; c.tr_write = 1'b1; c.tr_src = TRS_E; end
         OP_BINOP: begin c.tr_write = 1'b1; c.tr_src = TRS_C; c.dp_inc = DP_DEC; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   // Controls driven in the second execute cycle of two-cycle ops
   function automatic ctl_t ex2_ctl(input logic [2:0] op);
      ctl_t c;
      c = '0;
      case (op)
         OP_PUSH: begin c.reg_write = 1'b1; c.tr_write = 1'b1; c.tr_src = TRS_A; end
         OP_DUP:  c.reg_write = 1'b1;
         OP_OVER: begin c.reg_write = 1'b1; c.tr_write = 1'b1; c.tr_src = TRS_B; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ss_stack_depth_ctr.sv
// Saturating stack-depth counter with the accept-time legality compare.
module ss_stack_depth_ctr
   import ss_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       upd,
   input  logic [2:0] upd_op,
   input  logic [2:0] chk_op,
   output logic [8:0] depth,
   output logic       legal_c
);

   localparam logic [8:0] MAX_DEPTH = 9'(DEPTH);

   // Depth moves only when an executed op retires; never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= 9'd0;
      end else if (upd) begin
         if (is_grow(upd_op) && (depth != MAX_DEPTH)) begin
            depth <= depth + 9'd1;
         end else if (is_shrink(upd_op) && (depth != 9'd0)) begin
            depth <= depth - 9'd1;
         end
      end
   end

   always_comb begin
      legal_c = 1'b1;
      case (chk_op)
         OP_PUSH:           legal_c = (depth < MAX_DEPTH);
         OP_POP:            legal_c = (depth >= 9'd1);
         OP_DUP:            legal_c = (depth >= 9'd1) && (depth < MAX_DEPTH);
         OP_SWAP, OP_BINOP: legal_c = (depth >= 9'd2);
         OP_OVER:           legal_c = (depth >= 9'd2) && (depth < MAX_DEPTH);
         OP_RSVD:           legal_c = 1'b0;
         default:           legal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/ss_stack_sequencer.sv
// Data-stack control sequencer: one opcode per handshake, 1-2 cycle control bursts.
// SS_STACK_DEPTH_CHECK_EN adds depth tracking and rejection of illegal ops.
module ss_stack_sequencer
   import ss_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned DW    = 16
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          op_valid,
   input  logic [2:0]    op_code,
   output logic          op_ready,
   output logic          op_done,
   output logic          op_err,
   input  logic [DW-1:0] nos_data,
   output logic [DW-1:0] over_data,
   output logic [1:0]    dp_inc,
   output logic          regWrite,
   output logic          tr_write,
   output logic [2:0]    tr_src,
   output logic [8:0]    depth
);

   state_t     state;
   logic [2:0] op_q;
   logic       legal_c;

`ifdef SS_STACK_DEPTH_CHECK_EN
   logic upd_c;

   // op_done without op_err marks the last cycle of an executed op
   assign upd_c = op_done & ~op_err;

   ss_stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
      .clk     (CLK),
      .rst     (reset),
      .upd     (upd_c),
      .upd_op  (op_q),
      .chk_op  (op_code),
      .depth   (depth),
      .legal_c (legal_c)
   );
`else
   // No depth tracking: every opcode runs, reserved decodes to no controls
   assign legal_c = 1'b1;
   assign depth   = 9'(DEPTH) & 9'h000;
`endif

   // Outputs are registered from the next state and latched opcode
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_NOP;
         op_ready  <= 1'b1;
         op_done   <= 1'b0;
         op_err    <= 1'b0;
         dp_inc    <= DP_HOLD;
         regWrite  <= 1'b0;
         tr_write  <= 1'b0;
         tr_src    <= TRS_A;
         over_data <= '0;
      end else begin
         dp_inc   <= DP_HOLD;
         regWrite <= 1'b0;
         tr_write <= 1'b0;
         tr_src   <= TRS_A;
         op_done  <= 1'b0;
         op_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  op_q     <= op_code;
                  op_ready <= 1'b0;
                  if (legal_c) begin
                     state <= S_EX1;
                     {dp_inc, regWrite, tr_write, tr_src} <= ex1_ctl(op_code);
                     op_done <= ~two_cycle(op_code);
                  end else begin
                     state   <= S_REJ;
                     op_done <= 1'b1;
                     op_err  <= 1'b1;
                  end
               end
            end
            S_EX1: begin
               if (two_cycle(op_q)) begin
                  state <= S_EX2;
                  {dp_inc, regWrite, tr_write, tr_src} <= ex2_ctl(op_q);
                  op_done <= 1'b1;
                  if (op_q == OP_OVER) begin
                     over_data <= nos_data;
                  end
               end else begin
                  state    <= S_IDLE;
                  op_ready <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               op_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ss_stack_sequencer.sv
// Directed bench for ss_stack_sequencer (DEPTH=4); expectations follow
// SS_STACK_DEPTH_CHECK_EN when it is defined.
module tb_ss_stack_sequencer;

`ifdef SS_STACK_DEPTH_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   // {dp_inc, regWrite, tr_write, tr_src}
   localparam logic [6:0] C_NONE  = 7'b00_0_0_000;
   localparam logic [6:0] C_INC   = 7'b01_0_0_000;
   localparam logic [6:0] C_PUSH2 = 7'b00_1_1_000;
   localparam logic [6:0] C_POP   = 7'b10_0_1_100;
   localparam logic [6:0] C_DUP2  = 7'b00_1_0_000;
   localparam logic [6:0] C_SWAP  = 7'b00_1_1_100;
   localparam logic [6:0] C_OVER2 = 7'b00_1_1_001;
   localparam logic [6:0] C_BIN   = 7'b10_0_1_010;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic        op_ready, op_done, op_err;
   logic [15:0] nos_data = 16'h0;
   logic [15:0] over_data;
   logic [1:0]  dp_inc;
   logic        regWrite, tr_write;
   logic [2:0]  tr_src;
   logic [8:0]  depth;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_over = 16'h0;

   always #5 CLK = ~CLK;

   ss_stack_sequencer #(.DEPTH(4), .DW(16)) dut (
      .CLK(CLK), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready), .op_done(op_done), .op_err(op_err),
      .nos_data(nos_data), .over_data(over_data), .dp_inc(dp_inc),
      .regWrite(regWrite), .tr_write(tr_write), .tr_src(tr_src), .depth(depth)
   );

   wire [6:0] ctl = {dp_inc, regWrite, tr_write, tr_src};

   function automatic int ed(input int d);
      return CHK_EN ? d : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one opcode from IDLE and check every cycle through its return to IDLE
   task automatic run_op(input string name, input logic [2:0] op, input bit two,
                         input bit rej, input logic [6:0] c1, input logic [6:0] c2,
                         input int dep_after);
      @(negedge CLK);
      chk({name, ".ready"}, 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      op_code  = op;
      @(posedge CLK);
      #1 op_valid = 1'b0;
      op_code = 3'd0;
      @(negedge CLK);
      chk({name, ".ex1_ready"}, 32'(op_ready), 32'd0);
      chk({name, ".ex1_ctl"}, 32'(ctl), 32'(c1));
      chk({name, ".ex1_done"}, 32'(op_done), 32'(!two));
      chk({name, ".ex1_err"}, 32'(op_err), 32'(rej));
      if (two) begin
         @(negedge CLK);
         chk({name, ".ex2_ready"}, 32'(op_ready), 32'd0);
         chk({name, ".ex2_ctl"}, 32'(ctl), 32'(c2));
         chk({name, ".ex2_done"}, 32'(op_done), 32'd1);
         chk({name, ".ex2_err"}, 32'(op_err), 32'd0);
         chk({name, ".ex2_over"}, 32'(over_data), 32'(exp_over));
      end
      @(negedge CLK);
      chk({name, ".end_ready"}, 32'(op_ready), 32'd1);
      chk({name, ".end_ctl"}, 32'(ctl), 32'(C_NONE));
      chk({name, ".end_done"}, 32'(op_done), 32'd0);
      chk({name, ".end_depth"}, 32'(depth), 32'(dep_after));
      chk({name, ".end_over"}, 32'(over_data), 32'(exp_over));
   endtask

   initial begin
      // Reset state
      @(negedge CLK);
      chk("rst.ready", 32'(op_ready), 32'd1);
      chk("rst.ctl", 32'(ctl), 32'(C_NONE));
      chk("rst.done_err", 32'({op_done, op_err}), 32'd0);
      chk("rst.over", 32'(over_data), 32'd0);
      chk("rst.depth", 32'(depth), 32'd0);
      reset = 1'b0;

      // Empty-stack ops: rejected with checking, executed without
      run_op("pop_empty", 3'd2, 1'b0, CHK_EN, CHK_EN ? C_NONE : C_POP, C_NONE, 0);
      run_op("op7", 3'd7, 1'b0, CHK_EN, C_NONE, C_NONE, 0);
      run_op("dup_empty", 3'd3, !CHK_EN, CHK_EN, CHK_EN ? C_NONE : C_INC, C_DUP2, 0);

      run_op("push_a", 3'd1, 1'b1, 1'b0, C_INC, C_PUSH2, ed(1));
      run_op("push_b", 3'd1, 1'b1, 1'b0, C_INC, C_PUSH2, ed(2));

      // Reset in the middle of a PUSH drops the whole sequence
      @(negedge CLK);
      op_valid = 1'b1;
      op_code  = 3'd1;
      @(posedge CLK);
      #1 op_valid = 1'b0;
      @(negedge CLK);
      chk("midrst.ex1_ctl", 32'(ctl), 32'(C_INC));
      reset = 1'b1;
      #1;
      chk("midrst.ready", 32'(op_ready), 32'd1);
      chk("midrst.ctl", 32'(ctl), 32'(C_NONE));
      chk("midrst.done", 32'(op_done), 32'd0);
      chk("midrst.depth", 32'(depth), 32'd0);
      @(negedge CLK);
      reset = 1'b0;

      run_op("push_c", 3'd1, 1'b1, 1'b0, C_INC, C_PUSH2, ed(1));
      run_op("push_d", 3'd1, 1'b1, 1'b0, C_INC, C_PUSH2, ed(2));

      nos_data = 16'h1234;
      exp_over = 16'h1234;
      run_op("over", 3'd5, 1'b1, 1'b0, C_INC, C_OVER2, ed(3));
      nos_data = 16'h5555;
      run_op("swap", 3'd4, 1'b0, 1'b0, C_SWAP, C_NONE, ed(3));
      run_op("binop", 3'd6, 1'b0, 1'b0, C_BIN, C_NONE, ed(2));
      run_op("dup", 3'd3, 1'b1, 1'b0, C_INC, C_DUP2, ed(3));
      run_op("push_to_full", 3'd1, 1'b1, 1'b0, C_INC, C_PUSH2, ed(4));
      run_op("push_full", 3'd1, !CHK_EN, CHK_EN, CHK_EN ? C_NONE : C_INC, C_PUSH2, ed(4));

      // op_valid held high: re-accepted on the first IDLE cycle
      @(negedge CLK);
      op_valid = 1'b1;
      op_code  = 3'd0;
      @(negedge CLK);
      chk("b2b.first_done", 32'({op_ready, op_done}), 32'b01);
      @(negedge CLK);
      chk("b2b.idle", 32'({op_ready, op_done}), 32'b10);
      @(negedge CLK);
      chk("b2b.second_done", 32'({op_ready, op_done}), 32'b01);
      op_valid = 1'b0;
      @(negedge CLK);
      chk("b2b.depth", 32'(depth), 32'(ed(4)));

      run_op("pop_3", 3'd2, 1'b0, 1'b0, C_POP, C_NONE, ed(3));
      run_op("pop_2", 3'd2, 1'b0, 1'b0, C_POP, C_NONE, ed(2));
      run_op("pop_1", 3'd2, 1'b0, 1'b0, C_POP, C_NONE, ed(1));
      run_op("pop_0", 3'd2, 1'b0, 1'b0, C_POP, C_NONE, 0);
      run_op("pop_under", 3'd2, 1'b0, CHK_EN, CHK_EN ? C_NONE : C_POP, C_NONE, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ss_stack_sequencer.md
Name: ss_stack_sequencer

Overview:
- Control sequencer directly upstream of the 16-bit data stack.
- Accepts one stack opcode per handshake and drives the data stack's control inputs over 1–2 cycles: dp_inc, regWrite, tr_write, tr_src.
- Also captures next-on-stack (NOS) into a temp register for OVER and tracks stack depth.
- Stack model: TR holds top-of-stack (TOS); regfile[dp] holds NOS.

Parameters:
- DEPTH, 256, maximum stack entries including TR; legal range 2..256.
- DW, 16, data width of nos_data / over_data.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  opcode offered.
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 BINOP, 7 reserved.
- op_ready  out  1  sequencer can accept an opcode.
- op_done  out  1  one-cycle pulse in the final cycle of an operation.
- op_err  out  1  one-cycle pulse, coincident with op_done, when an operation is rejected.
- nos_data  in  DW  data stack read_data (regfile[dp]).
- over_data  out  DW  temp register; feeds data stack input b.
- dp_inc  out  2  00 hold, 01 increment, 10 decrement, 11 unused (never driven).
- regWrite  out  1  write TR to regfile[dp] at this edge.
- tr_write  out  1  load TR at this edge.
- tr_src  out  3  0 a (push literal), 1 b (over_data), 2 c (ALU result), 3 d, 4 e (regfile read).
- depth  out  9  current entry count, 0..DEPTH.

Behaviour:
- Reset: state IDLE; op_ready=1; all other outputs 0 (dp_inc=00, regWrite=0, tr_write=0, tr_src=0, over_data=0, depth=0, op_done=0, op_err=0).
- Reset asserted mid-operation aborts the sequence immediately; no partial depth update survives.
- States: IDLE, EX1, EX2, REJ.
- op_ready=1 only in IDLE. Accept when op_valid&&op_ready; latch op_code at that edge.
- All control outputs are decoded from state + latched opcode only (Moore); nothing is combinational from op_valid or op_code.
- Accepted legal op -> EX1. Rejected op -> REJ.
- Per-op sequences (unlisted controls are 0):
  - NOP: EX1 with no controls; op_done=1.
  - PUSH: EX1 dp_inc=01. EX2 regWrite=1, tr_write=1, tr_src=0. depth+1.
  - POP: EX1 tr_write=1, tr_src=4, dp_inc=10. depth-1.
  - DUP: EX1 dp_inc=01. EX2 regWrite=1. depth+1.
  - SWAP: EX1 regWrite=1, tr_write=1, tr_src=4. TR and regfile[dp] exchange on one edge. depth unchanged.
  - OVER: EX1 over_data<=nos_data, dp_inc=01. EX2 regWrite=1, tr_write=1, tr_src=1. depth+1.
  - BINOP: EX1 tr_write=1, tr_src=2, dp_inc=10. depth-1.
- Cycle timing:
  - The last EX state asserts op_done; the next state is IDLE.
  - Depth updates on the edge that leaves the last EX state.
  - One-cycle ops: accept edge N, controls and op_done in cycle N+1, op_ready again in cycle N+2.
  - Two-cycle ops: op_ready again in cycle N+3.
- Legality, evaluated at accept against current depth:
  - PUSH, DUP, OVER require depth<DEPTH.
  - POP requires depth>=1.
  - DUP requires depth>=1.
  - SWAP, OVER, BINOP require depth>=2.
  - op_code 7 is always illegal.
- REJ: one cycle; op_done=1, op_err=1; no controls asserted; depth unchanged; returns to IDLE.
- over_data holds its value until the next OVER.
- depth never wraps; the exact-boundary cases are DEPTH-1 -> DEPTH on push and 1 -> 0 on pop.
- Back-to-back: op_valid held high is accepted on the first IDLE cycle after op_done.

Optional Feature:
- Macro: SS_STACK_DEPTH_CHECK_EN.
- Defined: depth counter and legality checks as above; illegal ops go to REJ.
- Undefined:
  - No depth register; depth output tied 0 and op_err tied 0.
  - Every op 0–6 executes unconditionally.
  - op_code 7 is treated as NOP.

Decomposition:
- Shared package ss_stack_pkg holds:
  - opcode constants (OP_NOP..OP_RSVD);
  - dp_inc encodings (DP_HOLD, DP_INC, DP_DEC);
  - tr_src encodings (TRS_A..TRS_E);
  - state typedef.
- One natural sub-module: ss_stack_depth_ctr, a saturating up/down depth counter plus legality compare. It is instantiated only under SS_STACK_DEPTH_CHECK_EN.

Test Plan:
- reset asserted mid-PUSH in EX1 -> outputs return to 0 asynchronously; op_ready=1; depth=0.
- PUSH, PUSH -> controls per cycle as specified; depth=2; op_ready low exactly 2 cycles per op; op_done once per op.
- depth=2, nos_data=16'h1234, OVER -> over_data=16'h1234 after EX1; EX2 tr_src=1, regWrite=1, tr_write=1; depth=3.
- depth=3, SWAP then BINOP -> SWAP: one cycle, regWrite=tr_write=1, tr_src=4. BINOP: tr_src=2, dp_inc=10. depth=2.
- depth=0, POP; then op_code 7 -> each produces REJ with op_err=op_done=1, no controls, depth stays 0. Repeat with macro undefined -> POP executes; op 7 is a NOP; op_err stays 0.
- DEPTH=4: PUSH×4 then PUSH -> 5th rejected with op_err; depth=4. Then POP×4 -> depth=0 with no wrap.
